// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo
//   Elastic pipeline-stage buffer: a small FIFO of DEPTH entries, each holding
//   NUM_DATA data words plus a CTRL_W-bit control bundle, with valid/ready
//   handshakes on both sides, a synchronous flush and a saturating counter of
//   downstream stall cycles. Intended to replace the fixed MEM/WB register so
//   that writeback can stall without losing data.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous flush, drops every stored entry
//   in_valid   in   upstream entry valid
//   in_ready   out  buffer can take an entry this cycle (count < DEPTH)
//   in_data    in   NUM_DATA words, word k at [k*DATA_W +: DATA_W]
//   in_ctrl    in   control bundle
//   out_valid  out  head entry valid (count != 0)
//   out_ready  in   downstream takes the head this cycle
//   out_data   out  head data words, zero when empty
//   out_ctrl   out  head control bundle, zero when empty
//   count      out  number of stored entries
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready
module pipe_stage_fifo #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 2,
  parameter int CTRL_W   = 1,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_DATA*DATA_W-1:0]   in_data,
  input  logic [CTRL_W-1:0]            in_ctrl,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_DATA*DATA_W-1:0]   out_data,
  output logic [CTRL_W-1:0]            out_ctrl,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int WORD_W  = NUM_DATA * DATA_W;
  localparam int ENTRY_W = WORD_W + CTRL_W;
  localparam int CNT_B   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointer arithmetic and the count width assume a small buffer.
  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_stage_fifo: DEPTH must be in 1..8");
  end

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_B-1:0]   r_count;
  logic [CNT_W-1:0]   r_stall;

  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [PTR_W-1:0]   w_wr_ptr_inc;
  logic [PTR_W-1:0]   w_rd_ptr_inc;

  // Handshake status depends only on registered state, so in_ready never
  // combinationally follows out_ready.
  assign in_ready  = (r_count < CNT_B'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Explicit wrap so that non-power-of-two depths work.
  assign w_wr_ptr_inc = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_inc = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  // Empty stage presents all-zero data and control so no stale writeback
  // control can leak downstream.
  assign w_head   = r_mem[r_rd_ptr];
  assign out_data = out_valid ? w_head[WORD_W-1:0] : '0;
  assign out_ctrl = out_valid ? w_head[ENTRY_W-1:WORD_W] : '0;

  assign count     = r_count;
  assign stall_cnt = r_stall;

  // Storage: written only on an accepted push. A flushed push is still not
  // written, though writing would be harmless since the slot is masked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= {in_ctrl, in_data};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_B'(1);
        2'b01:   r_count <= r_count - CNT_B'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stall statistics: a flush cycle is not counted, and the counter sticks
  // at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (out_valid && !out_ready && !flush && (r_stall != '1)) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

endmodule
